rv32m_iter: RTL and testbench
=============================

Name: rv32m_iter

Overview:
- Parametrised, handshaked, multi-cycle RV M-extension execute unit. Successor to the fixed-32-bit rv32m block.
- Covers all eight funct3 ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for any XLEN.
- Uses an iterative radix-2 shift-add multiplier and a restoring divider.
- Sits in the EX stage beside the ALU. Ready/valid on both sides lets the pipeline stall on it.

Parameters:
- XLEN, 32: operand/result width (≥4, even).
- CNT_W, $clog2(XLEN)+1: iteration counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operands/funct3 valid
- in_ready  out  1  unit idle, can accept
- funct3  in  3  op select (000 MUL … 111 REMU, RV encoding)
- rs1  in  XLEN  operand 1
- rs2  in  XLEN  operand 2
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- rd  out  XLEN  result
- in_error  out  1  divide-by-zero flag, qualified by out_valid

Behaviour:
- Reset: state IDLE, in_ready=1, out_valid=0, rd=0, in_error=0, all datapath registers 0.
- Reset mid-operation is allowed. The next cycle is IDLE with out_valid=0, and the in-flight op is discarded.
- FSM has three states: IDLE, CALC, DONE.
- IDLE: in_ready=1.
  - On in_valid=1, latch funct3, rs1 and rs2.
  - Compute operand signs:
    - rs1 is signed for MULH, MULHSU, DIV, REM.
    - rs2 is signed for MULH, DIV, REM.
  - Take magnitudes of the operands.
  - Load counter with XLEN, then go to CALC.
  - Exception: a div/rem op with rs2==0 goes straight to DONE.
- CALC: one iteration per cycle, in_ready=0.
  - Multiply: 2*XLEN-bit accumulator. If the multiplier LSB is set, add the multiplicand into the upper half, then shift right 1.
  - Divide (restoring): shift the {rem,quot} pair left 1, trial-subtract the divisor from rem, set the quot LSB if the result is non-negative.
  - Counter decrements; at 0, go to DONE.
- Result fix-up is applied on the CALC→DONE edge and registered into rd.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ (signed ops only).
  - Remainder takes the dividend's sign.
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2XLEN-1:XLEN].
- Latency (accept edge to first cycle with out_valid=1):
  - XLEN+1 cycles for normal ops.
  - 1 cycle for divide-by-zero.
- Divide by zero (RV semantics):
  - DIV/DIVU: rd = all ones.
  - REM/REMU: rd = rs1.
  - in_error=1 in both cases.
- Signed overflow (DIV/REM with rs1 = 1<<(XLEN-1) and rs2 = all ones):
  - DIV rd = rs1; REM rd = 0; in_error=0.
  - Must fall out of the magnitude datapath naturally, with no special trap.
- DONE: out_valid=1, and rd/in_error are held stable until out_ready=1.
  - On handshake, go to IDLE with out_valid=0.
  - in_ready stays 0 in DONE, so there is no same-cycle re-accept. Peak throughput is 1 op per XLEN+2 cycles.
- in_valid and any operand changes outside IDLE are ignored.
- funct3 is only sampled at accept, so later changes do not affect the in-flight op.

Optional Feature:
- Macro: MD_EARLY_OUT_EN.
- Defined: IDLE goes straight to DONE with 1-cycle latency and in_error=0 when any of these holds:
  - a mul op with either operand magnitude 0 (rd=0);
  - a div/rem op with dividend magnitude < divisor magnitude (quotient 0, remainder = rs1 unchanged).
- Undefined: these cases take the full XLEN+1 cycles. Results are identical in both builds.

Test Plan:
- MUL rs1=0x00000007, rs2=0xFFFFFFFD, out_ready=1 → rd=0xFFFFFFEB, in_error=0, out_valid first high exactly 33 cycles after accept, in_ready=0 for that whole window.
- Full-width products:
  - MULH 0x80000000×0x80000000 → 0x40000000
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF
  - MULHU same operands → 0xFFFFFFFE
- Signed divide/remainder, each expecting in_error=0:
  - DIV 0xFFFFFFF9/0x00000002 → 0xFFFFFFFD
  - REM same operands → 0xFFFFFFFF
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000
  - REM same operands → 0x00000000
- Divide by zero, operands 0x00000064/0x00000000, each with in_error=1 and out_valid high 1 cycle after accept:
  - DIVU → 0xFFFFFFFF
  - REMU → 0x00000064
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling rs1/in_valid → rd, in_error and out_valid stay constant and in_ready=0. On out_ready=1, next cycle out_valid=0 and in_ready=1.
- Reset mid-CALC: assert rst for 1 cycle at iteration 10 of a DIVU → next cycle in_ready=1, out_valid=0, rd=0. A following MUL 3×5 returns 0x0000000F.

Source files
------------

// File: rtl/rv32m_iter.sv
// Iterative RV M-extension execute unit: radix-2 shift-add multiply, restoring divide.
// Optional macro MD_EARLY_OUT_EN: short-circuit trivial mul/div cases straight to DONE.
module rv32m_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd,
    output logic            in_error
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          f3_q, f3_d;
    logic                neg_q, neg_d;
    logic                rneg_q, rneg_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic [XLEN-1:0]     rd_q, rd_d;
    logic                err_q, err_d;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic s);
        return s ? -v : v;
    endfunction

    // Sign restoration: product/quotient by sign mismatch, remainder follows the dividend.
    function automatic logic [XLEN-1:0] fixup(input logic [2*XLEN-1:0] acc, input logic [2:0] f,
                                              input logic ng, input logic rng);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quot;
        logic [XLEN-1:0]   rem;
        prod = ng  ? -acc : acc;
        quot = ng  ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = rng ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (f[2])
            return f[1] ? rem : quot;
        return (f[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    endfunction

    logic            is_div, s1, s2;
    logic [XLEN-1:0] mag1, mag2;

    assign is_div = funct3[2];
    assign s1     = rs1[XLEN-1] & (funct3 == 3'b001 || funct3 == 3'b010 ||
                                   funct3 == 3'b100 || funct3 == 3'b110);
    assign s2     = rs2[XLEN-1] & (funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b110);
    assign mag1   = mag(rs1, s1);
    assign mag2   = mag(rs2, s2);

    logic            early;
    logic [XLEN-1:0] early_rd;

`ifdef MD_EARLY_OUT_EN
    assign early = is_div ? (mag1 < mag2) : (mag1 == '0 || mag2 == '0);
`else
    assign early = 1'b0;
`endif
    assign early_rd = (is_div && funct3[1]) ? rs1 : '0;

    // One iteration: acc holds {hi, multiplier} for mul, {rem, quot} for div.
    logic [XLEN:0]     mul_sum, div_rem, div_diff;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, step;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
    assign mul_nxt  = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    assign div_rem  = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff = div_rem - {1'b0, opb_q};
    assign div_nxt  = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    assign step     = f3_q[2] ? div_nxt : mul_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            acc_q   <= '0;
            opb_q   <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        rd_d    = rd_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    f3_d   = funct3;
                    neg_d  = s1 ^ s2;
                    rneg_d = s1;
                    err_d  = 1'b0;
                    cnt_d  = CNT_W'(XLEN);
                    acc_d  = {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
                    opb_d  = is_div ? mag2 : mag1;
                    if (is_div && rs2 == '0) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        rd_d    = funct3[1] ? rs1 : '1;
                    end else if (early) begin
                        state_d = DONE;
                        rd_d    = early_rd;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    rd_d    = fixup(step, f3_q, neg_q, rneg_q);
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign rd        = rd_q;
    assign in_error  = err_q;

endmodule

// File: tb/tb_rv32m_iter.sv
// Directed bench for rv32m_iter (XLEN=32): hand-computed results, latency and handshake checks.
module tb_rv32m_iter;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] rd;
    logic            in_error;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    rv32m_iter #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .rs1       (rs1),
        .rs2       (rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd        (rd),
        .in_error  (in_error)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // exp_lat <= 0 skips the latency check.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_rd,
                          input logic exp_err, input int exp_lat);
        int lat;
        int guard;
        logic busy_ok;
        guard = 0;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        funct3    = f;
        rs1       = a;
        rs2       = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = 1;
        busy_ok  = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ok = 1'b0;
            tick();
            lat++;
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_rd"}, rd, exp_rd);
        check({tag, "_err"}, in_error, exp_err);
        check({tag, "_inrdy_done"}, in_ready, 0);
        if (exp_lat > 0) begin
            check({tag, "_lat"}, lat, exp_lat);
            check({tag, "_inrdy_busy"}, busy_ok, 1);
        end
        tick();
        check({tag, "_vld_drop"}, out_valid, 0);
        check({tag, "_idle"}, in_ready, 1);
    endtask

    initial begin
        int guard;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        funct3    = 3'b000;
        rs1       = '0;
        rs2       = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_inrdy", in_ready, 1);
        check("rst_vld", out_valid, 0);
        check("rst_rd", rd, 0);
        check("rst_err", in_error, 0);

        run_op("mul_neg",   3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33);
        run_op("mulh",      3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33);
        run_op("mulhsu",    3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("mulhu",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 0);
        run_op("div_neg",   3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 33);
        run_op("rem_neg",   3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0);
        run_op("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 0);
        run_op("divu_z",    3'b101, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1);
        run_op("remu_z",    3'b111, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 1'b1, 1);
        run_op("div_negd",  3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 0);
        run_op("rem_negd",  3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
        run_op("divu",      3'b101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0, 0);
        run_op("remu",      3'b111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0, 0);
        run_op("mulhu_sm",  3'b011, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 1'b0, 0);

        // Backpressure: result must hold while the consumer stalls.
        funct3    = 3'b101;
        rs1       = 32'h0000_0064;
        rs2       = 32'h0000_0007;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        guard    = 0;
        while (!out_valid && guard < 100) begin
            tick();
            guard++;
        end
        check("bp_reached", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            rs1      = rs1 ^ 32'hA5A5_0F0F;
            in_valid = ~in_valid;
            tick();
            check("bp_rd", rd, 32'h0000_000E);
            check("bp_err", in_error, 0);
            check("bp_vld", out_valid, 1);
            check("bp_inrdy", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_vld", out_valid, 0);
        check("bp_release_inrdy", in_ready, 1);

        // Reset in the middle of a DIVU.
        funct3   = 3'b101;
        rs1      = 32'h0000_0064;
        rs2      = 32'h0000_0007;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_inrdy", in_ready, 1);
        check("mrst_vld", out_valid, 0);
        check("mrst_rd", rd, 0);
        check("mrst_err", in_error, 0);
        run_op("mul_after_rst", 3'b000, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 1'b0, 33);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
